// File: rtl/gate_sequence_multiplier.sv
// gate_sequence_multiplier
//
// Folds a stream of quantum-gate IDs into one 2x2 complex matrix product. The
// product is the compiled unitary. Each gate ID addresses an internal constant
// ROM of Q2.16 gate matrices. The running product is updated as
// P_new = P_old x G, so the first gate received is the leftmost factor. The
// actual complex multiply is done by an external multiplier, which this block
// drives through a one-cycle start strobe and a completion strobe.
//
// Matrix ports are indexed [row 0:1][col 0:1][0=re,1=im]. Each element is a
// signed W-bit Q2.16 value, where 1.0 = 65536.
//
// Ports
//   clk                in   single rising-edge clock
//   reset              in   synchronous, active-high
//   seq_index          in   position of the gate in the sequence (0 = last gate)
//   seq_gate           in   gate ID (ROM address)
//   ready              in   upstream strobe; index/gate/first valid this cycle
//   first              in   with ready, start a new sequence
//   available          out  high while idle and able to accept ready
//   result_mtx         out  running/final product, held between updates
//   done               out  one-cycle pulse when a full sequence product is valid
//   multiplier_a       out  left operand to the multiplier
//   multiplier_b       out  right operand to the multiplier
//   multiplier_result  in   product returned by the multiplier
//   multiplier_ready   out  one-cycle start strobe to the multiplier
//   multiplier_done    in   multiplier completion strobe
module gate_sequence_multiplier #(
  parameter int W     = 19,
  parameter int FRAC  = 16,
  parameter int IDXW  = 5,
  parameter int GATEW = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [IDXW-1:0]     seq_index,
  input  logic [GATEW-1:0]    seq_gate,
  input  logic                ready,
  input  logic                first,
  output logic                available,
  output logic signed [W-1:0] result_mtx [0:1][0:1][0:1],
  output logic                done,
  output logic signed [W-1:0] multiplier_a [0:1][0:1][0:1],
  output logic signed [W-1:0] multiplier_b [0:1][0:1][0:1],
  input  logic signed [W-1:0] multiplier_result [0:1][0:1][0:1],
  output logic                multiplier_ready,
  input  logic                multiplier_done
);

  typedef logic signed [W-1:0] mtx_t [0:1][0:1][0:1];

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_START  = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_FINISH = 3'd4;

  // Fixed-point constants: 1.0 and 1/sqrt(2) in Q2.16.
  localparam logic signed [W-1:0] ONE = W'(1 << FRAC);
  localparam logic signed [W-1:0] RT2 = W'(46341);
  localparam logic signed [W-1:0] NEG_ONE = -ONE;
  localparam logic signed [W-1:0] NEG_RT2 = -RT2;

  localparam logic [GATEW-1:0] G_H   = GATEW'(1);
  localparam logic [GATEW-1:0] G_X   = GATEW'(2);
  localparam logic [GATEW-1:0] G_Y   = GATEW'(3);
  localparam logic [GATEW-1:0] G_Z   = GATEW'(4);
  localparam logic [GATEW-1:0] G_S   = GATEW'(5);
  localparam logic [GATEW-1:0] G_T   = GATEW'(6);
  localparam logic [GATEW-1:0] G_SDG = GATEW'(7);
  localparam logic [GATEW-1:0] G_TDG = GATEW'(8);

  logic [2:0]       state_q, state_d;
  logic [IDXW-1:0]  index_q, index_d;
  logic [GATEW-1:0] gate_q, gate_d;
  logic             first_q, first_d;
  mtx_t             result_q, result_d;
  mtx_t             mult_a_q, mult_a_d;
  mtx_t             mult_b_q, mult_b_d;
  mtx_t             rom_g;

  // Gate ROM, addressed by the latched gate ID. Unused IDs (0 and 9..31)
  // decode to the identity, so an unknown gate leaves the product unchanged.
  always_comb begin
    rom_g = '{default: '0};
    case (gate_q)
      G_H: begin
        rom_g[0][0][0] = RT2;
        rom_g[0][1][0] = RT2;
        rom_g[1][0][0] = RT2;
        rom_g[1][1][0] = NEG_RT2;
      end
      G_X: begin
        rom_g[0][1][0] = ONE;
        rom_g[1][0][0] = ONE;
      end
      G_Y: begin
        rom_g[0][1][1] = NEG_ONE;
        rom_g[1][0][1] = ONE;
      end
      G_Z: begin
        rom_g[0][0][0] = ONE;
        rom_g[1][1][0] = NEG_ONE;
      end
      G_S: begin
        rom_g[0][0][0] = ONE;
        rom_g[1][1][1] = ONE;
      end
      G_T: begin
        rom_g[0][0][0] = ONE;
        rom_g[1][1][0] = RT2;
        rom_g[1][1][1] = RT2;
      end
      G_SDG: begin
        rom_g[0][0][0] = ONE;
        rom_g[1][1][1] = NEG_ONE;
      end
      G_TDG: begin
        rom_g[0][0][0] = ONE;
        rom_g[1][1][0] = RT2;
        rom_g[1][1][1] = NEG_RT2;
      end
      default: begin
        rom_g[0][0][0] = ONE;
        rom_g[1][1][0] = ONE;
      end
    endcase
  end

  // Sequencer. A first gate seeds the product directly from the ROM. Every
  // later gate goes through the external multiplier with the operands frozen
  // in flops, so they stay stable for the whole WAIT period. A ready strobe
  // outside IDLE and a multiplier_done outside WAIT simply fall through the
  // case arms with no effect.
  always_comb begin
    state_d  = state_q;
    index_d  = index_q;
    gate_d   = gate_q;
    first_d  = first_q;
    result_d = result_q;
    mult_a_d = mult_a_q;
    mult_b_d = mult_b_q;
    case (state_q)
      S_IDLE: begin
        if (ready) begin
          index_d = seq_index;
          gate_d  = seq_gate;
          first_d = first;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        if (first_q) begin
          result_d = rom_g;
          state_d  = S_FINISH;
        end else begin
          mult_a_d = result_q;
          mult_b_d = rom_g;
          state_d  = S_START;
        end
      end
      S_START: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (multiplier_done) begin
          result_d = multiplier_result;
          state_d  = S_FINISH;
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers. Reset aborts any operation in flight.
  // Because the state returns to IDLE, a late multiplier_done is never
  // consumed.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      index_q  <= '0;
      gate_q   <= '0;
      first_q  <= 1'b0;
      result_q <= '{default: '0};
      mult_a_q <= '{default: '0};
      mult_b_q <= '{default: '0};
    end else begin
      state_q  <= state_d;
      index_q  <= index_d;
      gate_q   <= gate_d;
      first_q  <= first_d;
      result_q <= result_d;
      mult_a_q <= mult_a_d;
      mult_b_q <= mult_b_d;
    end
  end

  assign available        = (state_q == S_IDLE);
  assign multiplier_ready = (state_q == S_START);
  // Only the step tagged index 0 closes a sequence.
  assign done             = (state_q == S_FINISH) && (index_q == '0);
  assign result_mtx       = result_q;
  assign multiplier_a     = mult_a_q;
  assign multiplier_b     = mult_b_q;

endmodule

// File: tb/tb_gate_sequence_multiplier.sv
// Testbench for gate_sequence_multiplier. It contains a behavioural model of
// the external complex matrix multiplier with a programmable latency, and a
// sequence-level reference that folds gate matrices into a running product.
module tb_gate_sequence_multiplier;

  localparam int W = 19;

  logic                clk = 1'b0;
  logic                reset;
  logic [4:0]          seq_index;
  logic [4:0]          seq_gate;
  logic                ready;
  logic                first;
  logic                available;
  logic                done;
  logic                multiplier_ready;
  logic                multiplier_done = 1'b0;
  logic signed [W-1:0] result_mtx [0:1][0:1][0:1];
  logic signed [W-1:0] multiplier_a [0:1][0:1][0:1];
  logic signed [W-1:0] multiplier_b [0:1][0:1][0:1];
  logic signed [W-1:0] multiplier_result [0:1][0:1][0:1] = '{default: '0};

  initial begin : clockGen
    forever #5 clk = ~clk;
  end

  gate_sequence_multiplier dut (
    .clk               (clk),
    .reset             (reset),
    .seq_index         (seq_index),
    .seq_gate          (seq_gate),
    .ready             (ready),
    .first             (first),
    .available         (available),
    .result_mtx        (result_mtx),
    .done              (done),
    .multiplier_a      (multiplier_a),
    .multiplier_b      (multiplier_b),
    .multiplier_result (multiplier_result),
    .multiplier_ready  (multiplier_ready),
    .multiplier_done   (multiplier_done)
  );

  int tests = 0;
  int fails = 0;

  // Gate matrices written out from their mathematical definitions.
  int rom_re [0:31][0:1][0:1];
  int rom_im [0:31][0:1][0:1];
  // Expected running product and expected multiplier operands.
  int p_re [0:1][0:1];
  int p_im [0:1][0:1];
  int opa_re [0:1][0:1];
  int opa_im [0:1][0:1];
  int opb_re [0:1][0:1];
  int opb_im [0:1][0:1];

  // Multiplier model state. Only the model block writes these, except
  // mult_lat and stray_tok, which only the main block writes.
  int mult_lat = 0;
  int stray_tok = 0;
  int stray_seen = 0;
  bit mult_busy = 1'b0;
  int mult_cnt = 0;
  bit mult_stale = 1'b0;
  bit stab_bad = 1'b0;
  int cap_a_re [0:1][0:1];
  int cap_a_im [0:1][0:1];
  int cap_b_re [0:1][0:1];
  int cap_b_im [0:1][0:1];
  int pend_re [0:1][0:1];
  int pend_im [0:1][0:1];

  typedef struct {
    bit f;
    int g;
    int idx;
    int re [4];
    int im [4];
    int dn;
    int mr;
  } vec_t;
  vec_t vecs [4];

  function automatic int wrapW(input longint v);
    logic signed [W-1:0] t;
    t = v[W-1:0];
    return int'(t);
  endfunction

  // Multiplier model. It runs on the falling edge, so its strobes are stable
  // at the DUT's rising edge. It latches the operands on start, answers after
  // mult_lat further cycles, and flags any operand change seen at completion
  // time. The stability check is skipped if the DUT was reset in between.
  always @(negedge clk) begin
    longint sr, si;
    multiplier_done = 1'b0;
    if (stray_tok != stray_seen) begin
      stray_seen = stray_tok;
      for (int i = 0; i < 2; i++)
        for (int j = 0; j < 2; j++) begin
          multiplier_result[i][j][0] = 19'sd12345;
          multiplier_result[i][j][1] = -19'sd777;
        end
      multiplier_done = 1'b1;
    end else if (multiplier_ready) begin
      for (int i = 0; i < 2; i++)
        for (int j = 0; j < 2; j++) begin
          cap_a_re[i][j] = int'(multiplier_a[i][j][0]);
          cap_a_im[i][j] = int'(multiplier_a[i][j][1]);
          cap_b_re[i][j] = int'(multiplier_b[i][j][0]);
          cap_b_im[i][j] = int'(multiplier_b[i][j][1]);
        end
      for (int i = 0; i < 2; i++)
        for (int j = 0; j < 2; j++) begin
          sr = 0;
          si = 0;
          for (int k = 0; k < 2; k++) begin
            sr += longint'(cap_a_re[i][k]) * cap_b_re[k][j] - longint'(cap_a_im[i][k]) * cap_b_im[k][j];
            si += longint'(cap_a_re[i][k]) * cap_b_im[k][j] + longint'(cap_a_im[i][k]) * cap_b_re[k][j];
          end
          pend_re[i][j] = wrapW(sr >>> 16);
          pend_im[i][j] = wrapW(si >>> 16);
        end
      mult_busy  = 1'b1;
      mult_cnt   = mult_lat + 1;
      mult_stale = 1'b0;
      stab_bad   = 1'b0;
    end else if (mult_busy) begin
      if (available) mult_stale = 1'b1;
      mult_cnt--;
      if (mult_cnt == 0) begin
        mult_busy = 1'b0;
        for (int i = 0; i < 2; i++)
          for (int j = 0; j < 2; j++) begin
            multiplier_result[i][j][0] = W'(pend_re[i][j]);
            multiplier_result[i][j][1] = W'(pend_im[i][j]);
            if (!mult_stale &&
                (int'(multiplier_a[i][j][0]) != cap_a_re[i][j] ||
                 int'(multiplier_a[i][j][1]) != cap_a_im[i][j] ||
                 int'(multiplier_b[i][j][0]) != cap_b_re[i][j] ||
                 int'(multiplier_b[i][j][1]) != cap_b_im[i][j]))
              stab_bad = 1'b1;
          end
        multiplier_done = 1'b1;
      end
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests++;
    if (actual != expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic checkResult(input string tag);
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        checkOutput($sformatf("%s re[%0d][%0d]", tag, i, j), int'(result_mtx[i][j][0]), p_re[i][j]);
        checkOutput($sformatf("%s im[%0d][%0d]", tag, i, j), int'(result_mtx[i][j][1]), p_im[i][j]);
      end
  endtask

  task automatic buildRom();
    int one, h;
    one = 65536;
    h = 46341;
    for (int g = 0; g < 32; g++)
      for (int i = 0; i < 2; i++)
        for (int j = 0; j < 2; j++) begin
          rom_re[g][i][j] = (i == j) ? one : 0;
          rom_im[g][i][j] = 0;
        end
    rom_re[1] = '{'{h, h}, '{h, -h}};
    rom_re[2] = '{'{0, one}, '{one, 0}};
    rom_re[3] = '{'{0, 0}, '{0, 0}};
    rom_im[3] = '{'{0, -one}, '{one, 0}};
    rom_re[4] = '{'{one, 0}, '{0, -one}};
    rom_re[5] = '{'{one, 0}, '{0, 0}};
    rom_im[5] = '{'{0, 0}, '{0, one}};
    rom_re[6] = '{'{one, 0}, '{0, h}};
    rom_im[6] = '{'{0, 0}, '{0, h}};
    rom_re[7] = '{'{one, 0}, '{0, 0}};
    rom_im[7] = '{'{0, 0}, '{0, -one}};
    rom_re[8] = '{'{one, 0}, '{0, h}};
    rom_im[8] = '{'{0, 0}, '{0, -h}};
  endtask

  // Reference: P := P x G, in Q2.16 with an arithmetic shift after summing.
  task automatic refMul(input int g);
    int tr [0:1][0:1];
    int ti [0:1][0:1];
    longint sr, si;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        sr = 0;
        si = 0;
        for (int k = 0; k < 2; k++) begin
          sr += longint'(p_re[i][k]) * rom_re[g][k][j] - longint'(p_im[i][k]) * rom_im[g][k][j];
          si += longint'(p_re[i][k]) * rom_im[g][k][j] + longint'(p_im[i][k]) * rom_re[g][k][j];
        end
        tr[i][j] = wrapW(sr >>> 16);
        ti[i][j] = wrapW(si >>> 16);
      end
    p_re = tr;
    p_im = ti;
  endtask

  task automatic clearModel();
    p_re = '{'{0, 0}, '{0, 0}};
    p_im = '{'{0, 0}, '{0, 0}};
  endtask

  // One request. It waits until the DUT is idle, pulses ready for one clock,
  // then watches until available returns, counting done pulses and start
  // strobes. With glitch set, a second ready is pulsed while the multiply is
  // outstanding.
  task automatic applyStimulus(input bit f, input int g, input int idx, input bit glitch,
                               output int ndone, output int nmreq);
    int w, cyc, exp_lat, bad;
    w = 0;
    @(negedge clk);
    while (!available && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!available) checkOutput("available before request", 0, 1);
    opa_re = p_re;
    opa_im = p_im;
    opb_re = rom_re[g];
    opb_im = rom_im[g];
    if (f) begin
      p_re = rom_re[g];
      p_im = rom_im[g];
    end else begin
      refMul(g);
    end
    exp_lat = f ? 3 : 5 + mult_lat;
    seq_gate  = 5'(g);
    seq_index = 5'(idx);
    first     = f;
    ready     = 1'b1;
    ndone = 0;
    nmreq = 0;
    cyc = -1;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (n == 1) ready = 1'b0;
      if (glitch && n == 3) begin
        seq_gate  = 5'd7;
        seq_index = 5'd0;
        first     = 1'b1;
        ready     = 1'b1;
      end
      if (glitch && n == 4) ready = 1'b0;
      if (done) ndone++;
      if (multiplier_ready) nmreq++;
      if (available) begin
        cyc = n;
        break;
      end
    end
    checkOutput($sformatf("latency gate %0d", g), cyc, exp_lat);
    checkOutput($sformatf("done count idx %0d", idx), ndone, (idx == 0) ? 1 : 0);
    checkOutput("multiplier_ready count", nmreq, f ? 0 : 1);
    checkResult($sformatf("result gate %0d", g));
    if (!f) begin
      bad = 0;
      for (int i = 0; i < 2; i++)
        for (int j = 0; j < 2; j++) begin
          if (cap_a_re[i][j] != opa_re[i][j] || cap_a_im[i][j] != opa_im[i][j]) bad++;
          if (cap_b_re[i][j] != opb_re[i][j] || cap_b_im[i][j] != opb_im[i][j]) bad++;
        end
      checkOutput("operand element errors", bad, 0);
      checkOutput("operands held in WAIT", int'(stab_bad), 0);
    end
  endtask

  task automatic setVec(input int n, input bit f, input int g, input int idx,
                        input int r0, input int r1, input int r2, input int r3,
                        input int i0, input int i1, input int i2, input int i3,
                        input int dn, input int mr);
    vecs[n].f = f;
    vecs[n].g = g;
    vecs[n].idx = idx;
    vecs[n].re = '{r0, r1, r2, r3};
    vecs[n].im = '{i0, i1, i2, i3};
    vecs[n].dn = dn;
    vecs[n].mr = mr;
  endtask

  task automatic countOperandNonzero(output int nz);
    nz = 0;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++)
        for (int c = 0; c < 2; c++) begin
          if (multiplier_a[i][j][c] != 0) nz++;
          if (multiplier_b[i][j][c] != 0) nz++;
        end
  endtask

  initial begin
    int nd, nm, nz, len, lo_avail;
    buildRom();
    clearModel();
    setVec(0, 1'b1, 2, 2, 0, 65536, 65536, 0, 0, 0, 0, 0, 0, 0);
    setVec(1, 1'b0, 1, 1, 46341, -46341, 46341, 46341, 0, 0, 0, 0, 0, 1);
    setVec(2, 1'b0, 0, 0, 46341, -46341, 46341, 46341, 0, 0, 0, 0, 1, 1);
    setVec(3, 1'b1, 5, 0, 65536, 0, 0, 0, 0, 0, 0, 65536, 1, 0);

    reset = 1'b1;
    ready = 1'b0;
    first = 1'b0;
    seq_gate = '0;
    seq_index = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset available", int'(available), 1);
    checkOutput("reset done", int'(done), 0);
    checkOutput("reset multiplier_ready", int'(multiplier_ready), 0);
    checkResult("reset result");
    countOperandNonzero(nz);
    checkOutput("reset operand nonzero elements", nz, 0);
    reset = 1'b0;

    // Directed vectors from hand-derived matrices.
    mult_lat = 2;
    for (int v = 0; v < 4; v++) begin
      applyStimulus(vecs[v].f, vecs[v].g, vecs[v].idx, 1'b0, nd, nm);
      for (int e = 0; e < 4; e++) begin
        checkOutput($sformatf("vec%0d re%0d", v, e), int'(result_mtx[e / 2][e % 2][0]), vecs[v].re[e]);
        checkOutput($sformatf("vec%0d im%0d", v, e), int'(result_mtx[e / 2][e % 2][1]), vecs[v].im[e]);
      end
      checkOutput($sformatf("vec%0d done", v), nd, vecs[v].dn);
      checkOutput($sformatf("vec%0d mreq", v), nm, vecs[v].mr);
    end

    // A completion strobe while idle must not touch the result.
    stray_tok++;
    nd = 0;
    lo_avail = 0;
    repeat (4) begin
      @(negedge clk);
      if (done) nd++;
      if (!available) lo_avail++;
    end
    checkOutput("stray done pulses", nd, 0);
    checkOutput("stray not-available cycles", lo_avail, 0);
    checkResult("stray result");

    // A ready strobe during WAIT is ignored.
    mult_lat = 4;
    applyStimulus(1'b1, 4, 1, 1'b0, nd, nm);
    applyStimulus(1'b0, 3, 0, 1'b1, nd, nm);
    lo_avail = 0;
    repeat (4) begin
      @(negedge clk);
      if (!available) lo_avail++;
    end
    checkOutput("glitch not-available cycles", lo_avail, 0);

    // Randomized sequences against the reference product.
    for (int s = 0; s < 15; s++) begin
      len = $urandom_range(1, 5);
      for (int k = 0; k < len; k++) begin
        mult_lat = $urandom_range(0, 4);
        applyStimulus(k == 0, $urandom_range(0, 31), len - 1 - k, 1'b0, nd, nm);
      end
    end

    // Reset while waiting on the multiplier. The late completion is ignored.
    mult_lat = 1;
    applyStimulus(1'b1, 1, 1, 1'b0, nd, nm);
    mult_lat = 8;
    @(negedge clk);
    seq_gate = 5'd3;
    seq_index = 5'd0;
    first = 1'b0;
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    nm = 0;
    for (int n = 0; n < 10 && nm == 0; n++) begin
      @(negedge clk);
      if (multiplier_ready) nm++;
    end
    checkOutput("abort start strobe seen", nm, 1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    clearModel();
    checkOutput("abort available", int'(available), 1);
    checkResult("abort result");
    countOperandNonzero(nz);
    checkOutput("abort operand nonzero elements", nz, 0);
    nd = 0;
    lo_avail = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) nd++;
      if (!available) lo_avail++;
    end
    checkOutput("abort late done pulses", nd, 0);
    checkOutput("abort not-available cycles", lo_avail, 0);
    checkResult("abort late result");

    // first=0 straight after reset multiplies the zero matrix.
    mult_lat = 1;
    applyStimulus(1'b0, 6, 0, 1'b0, nd, nm);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
